// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and divider helper for the UART blocks
//   rx_state_t : receiver FSM states
//   uart_div   : clk cycles per oversample tick, CLK_HZ / (BAUD*OVS)
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    function automatic int uart_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte/ready/clear port between the UART receiver and the CPU
//   dout[7:0] : last good byte        rdy       : byte available
//   rdy_clr   : consume pulse (CPU)   overrun   : sticky, byte lost
//   frame_err : sticky, bad stop bit  busy      : receiver not idle
//   master = CPU side, slave = receiver side
interface uart_rx_if;

    logic [7:0] dout;
    logic       rdy;
    logic       rdy_clr;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    modport master (output rdy_clr, input dout, rdy, overrun, frame_err, busy);
    modport slave  (input rdy_clr, output dout, rdy, overrun, frame_err, busy);

endinterface

// File: rtl/uart_tick.sv
// uart_tick: oversample tick generator, one-cycle pulse every DIV clocks
//   clk, rst_n : clock, async active-low reset
//   en         : run; counter is held at 0 while low so the phase restarts
//   tick       : pulse on count DIV-1
module uart_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = DIV > 1 ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && cnt == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!en || tick) ? '0 : cnt + W'(1);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with byte/ready/clear port and sticky error flags
//   clk, rst_n : clock, async active-low reset
//   rx         : serial line, idle high, asynchronous to clk
//   bus        : uart_rx_if.slave (dout, rdy, rdy_clr, overrun, frame_err, busy)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.slave  bus
);

    localparam int             DIV  = uart_div(CLK_HZ, BAUD, OVS);
    localparam int             TW   = $clog2(OVS);
    localparam logic [TW-1:0]  MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0]  LAST = TW'(OVS - 1);

    rx_state_t     state, state_n;
    logic          sync1, rx_s;
    logic          armed, armed_n;
    logic          tick;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          done_ok, done_bad;

    uart_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != IDLE),
        .tick (tick)
    );

    assign bus.busy = state != IDLE;

    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        armed_n  = armed;
        done_ok  = 1'b0;
        done_bad = 1'b0;
        case (state)
            IDLE: begin
                tcnt_n   = '0;
                bitcnt_n = '0;
                // a start edge only counts after the line has been seen high
                if (rx_s)
                    armed_n = 1'b1;
                else if (armed) begin
                    armed_n = 1'b0;
                    state_n = START;
                end
            end
            START: if (tick) begin
                tcnt_n = tcnt + TW'(1);
                if (tcnt == MID) begin
                    tcnt_n  = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: if (tick) begin
                tcnt_n = (tcnt == LAST) ? '0 : tcnt + TW'(1);
                if (tcnt == LAST) begin
                    shreg_n  = {rx_s, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: if (tick) begin
                tcnt_n = tcnt + TW'(1);
                if (tcnt == LAST) begin
                    tcnt_n   = '0;
                    state_n  = IDLE;
                    done_ok  = rx_s;
                    done_bad = !rx_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            armed         <= 1'b0;
            tcnt          <= '0;
            bitcnt        <= '0;
            shreg         <= '0;
            bus.dout      <= '0;
            bus.rdy       <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            sync1  <= rx;
            rx_s   <= sync1;
            state  <= state_n;
            armed  <= armed_n;
            tcnt   <= tcnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            if (done_ok)
                bus.dout <= shreg;
            // completion beats a simultaneous clear; the clear still drops overrun
            bus.rdy       <= done_ok | (bus.rdy & ~bus.rdy_clr);
            bus.overrun   <= ~bus.rdy_clr & (bus.overrun | (done_ok & bus.rdy));
            bus.frame_err <= done_bad | (bus.frame_err & ~bus.rdy_clr);
        end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + random frames against a byte-level model of the receiver
module tb_uart_rx;

    localparam int BIT = 160;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: what the CPU port should show after each frame
    logic [7:0] m_dout;
    logic       m_rdy, m_ovr, m_fe;

    int         rise_at;
    logic       snapped, snap_rdy, snap_ovr;
    logic [7:0] snap_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".dout"}, 32'(bus.dout), 32'(m_dout));
        check({tag, ".rdy"}, 32'(bus.rdy), 32'(m_rdy));
        check({tag, ".overrun"}, 32'(bus.overrun), 32'(m_ovr));
        check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_fe));
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic model_reset();
        m_dout = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input bit clr_first);
        if (clr_first) begin m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; end
        if (stop) begin
            m_ovr  = m_ovr | m_rdy;
            m_rdy  = 1'b1;
            m_dout = b;
        end else
            m_fe = 1'b1;
    endtask

    // drives the first 'upto' clocks of a frame, one clock per loop, at negedges;
    // clr_first pulses rdy_clr on clock 0, hold_clr keeps rdy_clr high from late
    // in the stop bit until busy drops and snapshots the outputs at that moment
    task automatic frame(input logic [7:0] b, input logic stop, input int upto,
                         input bit clr_first, input bit hold_clr);
        logic [9:0] bits;
        logic       prev;
        bits    = {stop, b, 1'b0};
        rise_at = -1;
        snapped = 1'b0;
        prev    = bus.rdy;
        for (int n = 0; n < upto; n++) begin
            @(negedge clk);
            if (bus.rdy && !prev && rise_at < 0) rise_at = n;
            prev = bus.rdy;
            bus.rdy_clr = clr_first && n == 0;
            if (hold_clr && n >= 1400 && !snapped) begin
                if (!bus.busy) begin
                    snapped   = 1'b1;
                    snap_rdy  = bus.rdy;
                    snap_ovr  = bus.overrun;
                    snap_dout = bus.dout;
                end else
                    bus.rdy_clr = 1'b1;
            end
            rx = bits[n / BIT];
        end
        bus.rdy_clr = 1'b0;
        rx = 1'b1;
    endtask

    task automatic clear();
        @(negedge clk);
        bus.rdy_clr = 1'b1;
        @(negedge clk);
        bus.rdy_clr = 1'b0;
        m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        bit         c;

        bus.rdy_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        idle(20);

        // reset in the middle of 0xA5 bit 3, then a clean 0x3C
        frame(8'hA5, 1'b1, BIT * 4 + 80, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        check_all("mid_reset");
        rx    = 1'b1;
        rst_n = 1'b1;
        idle(2 * BIT);
        frame(8'h3C, 1'b1, 10 * BIT, 0, 0);
        model_frame(8'h3C, 1'b1, 0);
        check_all("after_reset");
        clear();

        // basic byte, latency and clear
        frame(8'h55, 1'b1, 10 * BIT, 0, 0);
        model_frame(8'h55, 1'b1, 0);
        check("latency", 32'(rise_at >= 1512 && rise_at <= 1532), 32'd1);
        check_all("basic");
        clear();
        check("rdy_clr", 32'(bus.rdy), 32'd0);

        // back-to-back with a single stop bit, clear at the start of the next frame
        frame(8'h00, 1'b1, 10 * BIT, 0, 0);
        model_frame(8'h00, 1'b1, 0);
        check("b2b0.rise", 32'(rise_at >= 0), 32'd1);
        check_all("b2b0");
        frame(8'hFF, 1'b1, 10 * BIT, 1, 0);
        model_frame(8'hFF, 1'b1, 1);
        check("b2b1.rise", 32'(rise_at >= 0), 32'd1);
        check_all("b2b1");
        frame(8'h81, 1'b1, 10 * BIT, 1, 0);
        model_frame(8'h81, 1'b1, 1);
        check("b2b2.rise", 32'(rise_at >= 0), 32'd1);
        check_all("b2b2");
        clear();

        // overrun, then a clear coinciding with completion
        frame(8'h12, 1'b1, 10 * BIT, 0, 0);
        model_frame(8'h12, 1'b1, 0);
        check_all("ovr0");
        frame(8'h34, 1'b1, 10 * BIT, 0, 0);
        model_frame(8'h34, 1'b1, 0);
        check_all("ovr1");
        frame(8'h56, 1'b1, 10 * BIT, 0, 1);
        check("coincide.seen", 32'(snapped), 32'd1);
        check("coincide.rdy", 32'(snap_rdy), 32'd1);
        check("coincide.dout", 32'(snap_dout), 32'h56);
        check("coincide.overrun", 32'(snap_ovr), 32'd0);
        m_rdy = 1'b1; m_ovr = 1'b0; m_fe = 1'b0; m_dout = 8'h56;
        check_all("coincide");
        clear();

        // stop bit low
        frame(8'h7E, 1'b0, 10 * BIT, 0, 0);
        model_frame(8'h7E, 1'b0, 0);
        check_all("frame_err");
        clear();
        idle(20);

        // 40-clk glitch on an idle line
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch.busy_hi", 32'(bus.busy), 32'd1);
        idle(2 * BIT);
        check_all("glitch");

        // line stuck low past a whole frame: one frame error, no retrigger while low
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        m_fe = 1'b1;
        check_all("stuck");
        clear();
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check_all("stuck_hold");
        idle(BIT);
        check_all("stuck_release");

        // random bytes, stop bits, clears and gaps
        for (int i = 0; i < 10; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = $urandom_range(0, 3) != 0;
            c    = 1'($urandom_range(0, 1));
            idle($urandom_range(10, 40));
            frame(b, stop, 10 * BIT, c, 0);
            model_frame(b, stop, c);
            check_all($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
